dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
// - Data-memory responder: the far end of the MEM stage's load/store port.
// - Accepts one request at a time over a valid/ready handshake and serves it from an internal word RAM.
// - Responds after a fixed, parameterised latency. Loads return byte/half/word data, sign- or zero-extended.
// - The MEM stage stalls until resp_valid. The loaded value then feeds the wdata_i -> wdata_o writeback path.
// PARAMETERS
// - DEPTH_WORDS  1024  RAM size in 32-bit words; power of two, >= 2
// - LATENCY      2     cycles from request accept to resp_valid; integer >= 1
// PORTS
// - clk          in   1   single clock, rising edge
// - rst          in   1   reset, asynchronous assert, active-LOW (0 = reset)
// - req_valid    in   1   request present
// - req_ready    out  1   responder can accept (high only in IDLE)
// - req_we       in   1   1 = store, 0 = load
// - req_size     in   2   00 byte, 01 half, 10 word, 11 reserved
// - req_unsigned in   1   load zero-extend (1) / sign-extend (0)
// - req_addr     in   32  byte address, little-endian
// - req_wdata    in   32  store data, right-justified
// - resp_valid   out  1   one-cycle response pulse
// - resp_rdata   out  32  extended load data; 0 for stores
// - resp_err     out  1   misaligned access flag (only with MISALIGN_CHECK_EN)
// BEHAVIOUR
// - Reset values (asynchronous, rst==0):
//   - state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, latency counter = 0.
//   - RAM contents are not reset.
// - FSM states: IDLE, WAIT, RESP.
//   - Accept when req_valid && req_ready. Capture we/size/unsigned/addr/wdata into registers.
//   - On accept: if LATENCY == 1, go to RESP. Otherwise load counter with LATENCY-2 and go to WAIT.
//   - WAIT: if counter == 0, go to RESP; else decrement.
//   - RESP: resp_valid = 1 for exactly one cycle, then return to IDLE. req_ready = 0 in this cycle.
//   - An accept at edge T gives resp_valid high in cycle T+LATENCY. Next accept is no earlier than the following edge.
// - Request inputs are ignored outside IDLE. No back-to-back accept; throughput is 1 per LATENCY+1 cycles.
// - Addressing:
//   - Word index = req_addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses wrap around modulo the RAM size.
//   - Byte lane = addr[1:0]; half lane = addr[1].
// - Read/write timing:
//   - Read: array word is read on the edge entering RESP, then lane-extracted and extended. Word loads ignore req_unsigned.
//   - Store: byte-enable write of the lane(s) only, committed on the edge entering RESP. resp_rdata = 0.
// - size 11 behaves as word.
// - Reset mid-operation: a pending store that has not reached RESP is dropped; the RAM is unchanged. The FSM restarts in IDLE.
// - Sanity requirement: a load after a store to the same address returns the stored data (no hazard, one request at a time).
// CONFIGURATION
// - Macro: DMEM_MISALIGN_CHECK_EN.
// - Defined:
//   - resp_err port exists.
//   - A request is misaligned when (half && addr[0]) || (word && addr[1:0] != 0) || size == 11.
//   - A misaligned request follows the same latency, writes nothing, returns resp_rdata = 0 and resp_err = 1 with resp_valid.
// - Undefined:
//   - No resp_err port.
//   - Low address bits below the access size are ignored (forced alignment).
//   - size 11 is treated as word.
// STRUCTURE
// - Shared defines file: size encodings MemByte/MemHalf/MemWord, DMEM FSM state encodings.
//   - ZeroWord is reused from the existing shared definitions.
// - Sub-module dmem_lane_extract (combinational): {rdata_word, addr[1:0], size, unsigned} -> extended 32-bit load value.
//   - The same module generates the store byte-enables and the shifted write data.
// TESTING
// - Reset release with LATENCY=2: req_ready = 1, resp_valid = 0. Assert rst low mid-WAIT -> IDLE next cycle, resp_valid never pulses.
// - Store word 0xDEADBEEF @0x10, then load word @0x10 -> rdata 0xDEADBEEF. resp_valid exactly 2 cycles after each accept.
// - Load byte @0x13, signed -> 0xFFFFFFDE; unsigned -> 0x000000DE. Load half @0x12, signed -> 0xFFFFDEAD.
// - Store byte 0x55 @0x11 over 0xDEADBEEF, then load word @0x10 -> 0xDEAD55EF (other lanes untouched).
// - DEPTH_WORDS=1024: store @0x1000_0004, then load @0x4 -> same data (wrap-around). req_valid held high while busy -> exactly one accept per transaction.
// - With DMEM_MISALIGN_CHECK_EN: store half @0x21 -> resp_err = 1 and RAM unchanged; load word @0x22 -> resp_err = 1, rdata 0.
//   Without the macro: load word @0x22 returns the word @0x20.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared access-size and FSM state encodings for the data-memory responder
package dmem_responder_pkg;
   typedef enum logic [1:0] {MemByte = 2'b00, MemHalf = 2'b01, MemWord = 2'b10, MemRsvd = 2'b11} mem_size_e;
   typedef enum logic [1:0] {DmemIdle = 2'b00, DmemWait = 2'b01, DmemResp = 2'b10} dmem_state_e;
   localparam logic [31:0] ZeroWord = 32'h0000_0000;
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      return (size == MemHalf && lane[0]) || (size == MemWord && lane != 2'b00) || size == MemRsvd;
   endfunction
endpackage

// File: rtl/dmem_lane_extract.sv
// dmem_lane_extract: lane select and sign/zero extension for loads, byte enables and lane-replicated data for stores
module dmem_lane_extract
   import dmem_responder_pkg::*;
(
   input  logic [31:0] rdata_word,
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata_lane
);
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      b = rdata_word[{lane, 3'b000} +: 8];
      h = lane[1] ? rdata_word[31:16] : rdata_word[15:0];
      load_data = size == MemByte ? {{24{b[7] & ~uns}}, b}
                : size == MemHalf ? {{16{h[15] & ~uns}}, h} : rdata_word;
      byte_en = size == MemByte ? 4'b0001 << lane
              : size == MemHalf ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      // replicate the data across all lanes; byte_en picks the lane(s) actually written
      wdata_lane = size == MemByte ? {4{wdata[7:0]}}
                 : size == MemHalf ? {2{wdata[15:0]}} : wdata;
   end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency valid/ready load/store responder backed by a word RAM.
// Define DMEM_MISALIGN_CHECK_EN to flag misaligned requests on resp_err instead of forcing alignment.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata
`ifdef DMEM_MISALIGN_CHECK_EN
   ,
   output logic        resp_err
`endif
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(LATENCY + 1);
   dmem_state_e    state, next_state;
   logic [CW-1:0]  cnt;
   logic           r_we, r_uns;
   logic [1:0]     r_size;
   logic [AW+1:0]  r_addr;
   logic [31:0]    r_wdata;
   logic [31:0]    mem [DEPTH_WORDS];
   logic           accept, enter_resp, err;
   logic           cur_we, cur_uns;
   logic [1:0]     cur_size;
   logic [AW+1:0]  cur_addr;
   logic [31:0]    cur_wdata, load_data, wdata_lane;
   logic [3:0]     byte_en;
   logic           unused_addr;
   assign unused_addr = ^req_addr[31:AW+2];
   assign req_ready = state == DmemIdle;
   always_comb begin
      next_state = state;
      next_state = state == DmemIdle ? (req_valid ? (LATENCY == 1 ? DmemResp : DmemWait) : DmemIdle)
                 : state == DmemWait ? (cnt == '0 ? DmemResp : DmemWait) : DmemIdle;
      accept     = state == DmemIdle && req_valid;
      enter_resp = next_state == DmemResp;
   end
   // with LATENCY 1 the RESP edge is also the accept edge, so the live request is used
   always_comb begin
      cur_we    = state == DmemIdle ? req_we : r_we;
      cur_uns   = state == DmemIdle ? req_unsigned : r_uns;
      cur_size  = state == DmemIdle ? req_size : r_size;
      cur_addr  = state == DmemIdle ? req_addr[AW+1:0] : r_addr;
      cur_wdata = state == DmemIdle ? req_wdata : r_wdata;
   end
`ifdef DMEM_MISALIGN_CHECK_EN
   assign err = is_misaligned(cur_size, cur_addr[1:0]);
`else
   assign err = 1'b0;
`endif
   dmem_lane_extract u_lane (
      .rdata_word (mem[cur_addr[AW+1:2]]),
      .lane       (cur_addr[1:0]),
      .size       (cur_size),
      .uns        (cur_uns),
      .wdata      (cur_wdata),
      .load_data  (load_data),
      .byte_en    (byte_en),
      .wdata_lane (wdata_lane)
   );
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= DmemIdle;
         cnt        <= '0;
         r_we       <= 1'b0;
         r_uns      <= 1'b0;
         r_size     <= MemByte;
         r_addr     <= '0;
         r_wdata    <= ZeroWord;
         resp_valid <= 1'b0;
         resp_rdata <= ZeroWord;
`ifdef DMEM_MISALIGN_CHECK_EN
         resp_err   <= 1'b0;
`endif
      end else begin
         state <= next_state;
         if (accept) begin
            r_we    <= req_we;
            r_uns   <= req_unsigned;
            r_size  <= req_size;
            r_addr  <= req_addr[AW+1:0];
            r_wdata <= req_wdata;
         end
         cnt <= accept ? CW'(LATENCY > 1 ? LATENCY - 2 : 0)
              : (state == DmemWait && cnt != '0) ? cnt - 1'b1 : cnt;
         resp_valid <= enter_resp;
         resp_rdata <= enter_resp && !cur_we && !err ? load_data : ZeroWord;
`ifdef DMEM_MISALIGN_CHECK_EN
         resp_err   <= enter_resp && err;
`endif
      end
   end
   // stores commit only on the RESP edge, so a reset before then leaves the RAM untouched
   always_ff @(posedge clk) begin
      if (enter_resp && cur_we && !err)
         for (int i = 0; i < 4; i++)
            if (byte_en[i]) mem[cur_addr[AW+1:2]][8*i +: 8] <= wdata_lane[8*i +: 8];
   end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized self-checking bench against a byte-array model of the responder
module tb_dmem_responder;
   localparam int LATENCY = 2;
`ifdef DMEM_MISALIGN_CHECK_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err_w;
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  mb [4096];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LATENCY)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata)
`ifdef DMEM_MISALIGN_CHECK_EN
      ,
      .resp_err     (resp_err_w)
`endif
   );
`ifndef DMEM_MISALIGN_CHECK_EN
   assign resp_err_w = 1'b0;
`endif

   function automatic bit mis(input logic [1:0] size, input logic [1:0] a);
      return (size == 2'd1 && a[0]) || (size == 2'd2 && a != 2'd0) || size == 2'd3;
   endfunction

   function automatic int nbytes(input logic [1:0] size);
      return size == 2'd0 ? 1 : size == 2'd1 ? 2 : 4;
   endfunction

   // RAM is 4 KiB, so only the low 12 address bits matter; unaligned bits are dropped per access size
   function automatic logic [11:0] base(input logic [1:0] size, input logic [31:0] a);
      int n;
      n = nbytes(size);
      return a[11:0] - 12'(a[11:0] % n);
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] size, input logic uns);
      logic [31:0] v;
      logic [11:0] b;
      int n;
      v = 32'h0;
      n = nbytes(size);
      b = base(size, a);
      for (int i = 0; i < n; i++) v[8*i +: 8] = mb[b + 12'(i)];
      if (n == 1) return uns ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
      if (n == 2) return uns ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      return v;
   endfunction

   task automatic model_store(input logic [31:0] a, input logic [1:0] size, input logic [31:0] d);
      logic [11:0] b;
      b = base(size, a);
      for (int i = 0; i < nbytes(size); i++) mb[b + 12'(i)] = d[8*i +: 8];
   endtask

   task automatic do_req(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit hold, output logic [31:0] rd, output logic er,
                         output int lat, output int extra);
      @(negedge clk);
      req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) req_valid = 1'b0;
      rd = 'x; er = 'x; lat = -1; extra = 0;
      for (int c = 1; c <= LATENCY + 8 && lat < 0; c++) begin
         @(negedge clk);
         if (resp_valid) begin
            lat = c; rd = resp_rdata; er = resp_err_w;
         end else if (req_ready && req_valid) extra++;
      end
      req_valid = 1'b0;
   endtask

   task automatic op(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                     input logic [31:0] wdata, input bit hold, output logic [31:0] rd, output logic er,
                     output int lat, output int extra, output logic [31:0] exp_rd, output logic exp_er);
      exp_er = MIS_EN && mis(size, addr[1:0]);
      exp_rd = (we || exp_er) ? 32'h0 : model_load(addr, size, uns);
      if (we && !exp_er) model_store(addr, size, wdata);
      do_req(we, size, uns, addr, wdata, hold, rd, er, lat, extra);
   endtask

   task automatic test_reset;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", req_ready); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", resp_valid); end
      checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", resp_rdata); end
      checks++; if (resp_err_w !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", resp_err_w); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL rel_state got ready=%b valid=%b want 1/0", req_ready, resp_valid); end
   endtask

   task automatic test_fill;
      logic [31:0] rd, erd;
      logic er, eer;
      int lat, ex;
      for (int w = 0; w < 1024; w++) begin
         op(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 1'b0, rd, er, lat, ex, erd, eer);
         checks++; if (lat !== LATENCY || rd !== 32'h0) begin errors++; $display("FAIL fill_%0d got lat=%0d rd=%h want lat=%0d rd=0", w, lat, rd, LATENCY); end
      end
   endtask

   task automatic test_reset_mid_op;
      logic [31:0] old, rd, erd;
      logic er, eer;
      int lat, ex, pulses;
      old = model_load(32'h40, 2'd2, 1'b0);
      @(negedge clk);
      req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h40; req_wdata = ~old;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_busy got ready=%b want 0", req_ready); end
      rst = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst got ready=%b valid=%b want 1/0", req_ready, resp_valid); end
      pulses = 0;
      repeat (3) begin
         @(negedge clk);
         if (resp_valid) pulses++;
      end
      rst = 1'b1;
      checks++; if (pulses != 0) begin errors++; $display("FAIL mid_pulse got %0d want 0", pulses); end
      op(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0, rd, er, lat, ex, erd, eer);
      checks++; if (rd !== old) begin errors++; $display("FAIL mid_ram got %h want %h", rd, old); end
   endtask

   task automatic test_directed;
      logic [31:0] rd, erd;
      logic er, eer;
      int lat, ex;
      op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, rd, er, lat, ex, erd, eer);
      checks++; if (lat !== LATENCY || rd !== 32'h0) begin errors++; $display("FAIL st_word got lat=%0d rd=%h want %0d/0", lat, rd, LATENCY); end
      op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat, ex, erd, eer);
      checks++; if (lat !== LATENCY || rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_word got lat=%0d rd=%h want %0d/deadbeef", lat, rd, LATENCY); end
      op(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0, rd, er, lat, ex, erd, eer);
      checks++; if (rd !== 32'hFFFFFFDE) begin errors++; $display("FAIL ld_byte_s got %h want ffffffde", rd); end
      op(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0, rd, er, lat, ex, erd, eer);
      checks++; if (rd !== 32'h000000DE) begin errors++; $display("FAIL ld_byte_u got %h want 000000de", rd); end
      op(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b0, rd, er, lat, ex, erd, eer);
      checks++; if (rd !== 32'hFFFFDEAD) begin errors++; $display("FAIL ld_half_s got %h want ffffdead", rd); end
      op(1'b1, 2'd0, 1'b0, 32'h11, 32'h55, 1'b0, rd, er, lat, ex, erd, eer);
      op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat, ex, erd, eer);
      checks++; if (rd !== 32'hDEAD55EF) begin errors++; $display("FAIL st_byte_lane got %h want dead55ef", rd); end
   endtask

   task automatic test_wrap_hold;
      logic [31:0] rd, erd;
      logic er, eer;
      int lat, ex;
      op(1'b1, 2'd2, 1'b0, 32'h1000_0004, 32'h0BADF00D, 1'b1, rd, er, lat, ex, erd, eer);
      checks++; if (ex != 0 || lat !== LATENCY) begin errors++; $display("FAIL hold_st got extra=%0d lat=%0d want 0/%0d", ex, lat, LATENCY); end
      op(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 1'b1, rd, er, lat, ex, erd, eer);
      checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL wrap got %h want 0badf00d", rd); end
      checks++; if (ex != 0) begin errors++; $display("FAIL hold_ld got extra=%0d want 0", ex); end
   endtask

   task automatic test_misalign;
      logic [31:0] rd, erd;
      logic er, eer;
      int lat, ex;
      op(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 1'b0, rd, er, lat, ex, erd, eer);
`ifdef DMEM_MISALIGN_CHECK_EN
      op(1'b1, 2'd1, 1'b0, 32'h21, 32'h0000AAAA, 1'b0, rd, er, lat, ex, erd, eer);
      checks++; if (er !== 1'b1 || rd !== 32'h0 || lat !== LATENCY) begin errors++; $display("FAIL mis_st got err=%b rd=%h lat=%0d want 1/0/%0d", er, rd, lat, LATENCY); end
      op(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, rd, er, lat, ex, erd, eer);
      checks++; if (rd !== 32'h11223344 || er !== 1'b0) begin errors++; $display("FAIL mis_ram got %h err=%b want 11223344/0", rd, er); end
      op(1'b0, 2'd2, 1'b0, 32'h22, 32'h0, 1'b0, rd, er, lat, ex, erd, eer);
      checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL mis_ld got err=%b rd=%h want 1/0", er, rd); end
`else
      op(1'b0, 2'd2, 1'b0, 32'h22, 32'h0, 1'b0, rd, er, lat, ex, erd, eer);
      checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL align_ld got %h want 11223344", rd); end
`endif
   endtask

   task automatic test_random;
      logic [31:0] rd, erd, a;
      logic er, eer, we, uns;
      logic [1:0] sz;
      int lat, ex;
      for (int n = 0; n < 300; n++) begin
         we = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         uns = 1'($urandom_range(0, 1));
         a = $urandom;
         op(we, sz, uns, a, $urandom, bit'($urandom_range(0, 1)), rd, er, lat, ex, erd, eer);
         checks++; if (rd !== erd) begin errors++; $display("FAIL rnd_rdata #%0d we=%b sz=%0d a=%h got %h want %h", n, we, sz, a, rd, erd); end
         checks++; if (er !== eer) begin errors++; $display("FAIL rnd_err #%0d got %b want %b", n, er, eer); end
         checks++; if (lat !== LATENCY || ex != 0) begin errors++; $display("FAIL rnd_timing #%0d got lat=%0d extra=%0d want %0d/0", n, lat, ex, LATENCY); end
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      test_reset;
      test_fill;
      test_reset_mid_op;
      test_directed;
      test_wrap_hold;
      test_misalign;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
